sgf_norm_round: RTL and testbench

// Consumes the 2*W_Sgf+2-bit significand product and the pre-computed biased exponent; normalizes,

---
 rtl/sgf_norm_round_if.sv | 25 ++
 rtl/sgf_norm_round.sv | 109 ++++++++++
 tb/tb_sgf_norm_round.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sgf_norm_round_if.sv
// Handshake and data bundle between the product register and the normalize/round stage.
interface sgf_norm_round_if #(
    parameter int W_Sgf = 53,
    parameter int W_Exp = 11
);
    logic                 start;
    logic [2*W_Sgf+1:0]   P_Sgf;
    logic [W_Exp:0]       Exp_In;
    logic                 busy;
    logic                 done;
    logic [W_Sgf-2:0]     Sgf_Out;
    logic [W_Exp-1:0]     Exp_Out;
    logic                 Ovf_Flag;
    logic                 Zero_Flag;

    modport master (
        output start, P_Sgf, Exp_In,
        input  busy, done, Sgf_Out, Exp_Out, Ovf_Flag, Zero_Flag
    );

    modport slave (
        input  start, P_Sgf, Exp_In,
        output busy, done, Sgf_Out, Exp_Out, Ovf_Flag, Zero_Flag
    );
endinterface

// File: rtl/sgf_norm_round.sv
// FP multiplier back end: normalizes the significand product, rounds to nearest-even,
// renormalizes on rounding carry and saturates to infinity on exponent overflow.
module sgf_norm_round #(
    parameter int W_Sgf = 53,
    parameter int W_Exp = 11
) (
    input  logic             clk,
    input  logic             rst,
    sgf_norm_round_if.slave  bus
);
    localparam int EW = W_Exp + 1;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {W_Exp{1'b1}}};

    typedef enum logic [2:0] {IDLE, NORM, ROUND, RENORM, DONE} state_t;

    state_t               state;
    logic [2*W_Sgf-1:0]   prod_q;
    logic [EW-1:0]        exp_q;
    logic [W_Sgf-1:0]     mant_q;
    logic                 guard_q;
    logic                 sticky_q;
    logic                 zero_q;
    logic [W_Sgf:0]       sum_q;

    // Top two product bits are guaranteed zero; hidden bit of the rounded sum is implied.
    logic unused_bits;
    assign unused_bits = ^{bus.P_Sgf[2*W_Sgf+1:2*W_Sgf], sum_q[W_Sgf-1]};

    logic                 hi;
    logic [2*W_Sgf-2:0]   norm_bits;
    logic                 sticky_n;
    assign hi        = prod_q[2*W_Sgf-1];
    assign norm_bits = hi ? prod_q[2*W_Sgf-1:1] : prod_q[2*W_Sgf-2:0];
    assign sticky_n  = (|norm_bits[W_Sgf-3:0]) | (hi & prod_q[0]);

    logic                 round_up;
    logic [W_Sgf:0]       sum_n;
    assign round_up = guard_q & (sticky_q | mant_q[0]);
    assign sum_n    = {1'b0, mant_q} + {{W_Sgf{1'b0}}, round_up};

    logic [EW-1:0]        exp_r;
    logic [W_Sgf-2:0]     frac_r;
    logic                 ovf_r;
    assign exp_r  = exp_q + {{W_Exp{1'b0}}, sum_q[W_Sgf]};
    assign frac_r = sum_q[W_Sgf] ? '0 : sum_q[W_Sgf-2:0];
    assign ovf_r  = (exp_r >= EXP_MAX);

    // NOTE: only control and output registers are reset; datapath registers are
    // always written before they are read, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.Sgf_Out   <= '0;
            bus.Exp_Out   <= '0;
            bus.Ovf_Flag  <= 1'b0;
            bus.Zero_Flag <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    prod_q   <= bus.P_Sgf[2*W_Sgf-1:0];
                    exp_q    <= bus.Exp_In;
                    bus.busy <= 1'b1;
                    state    <= NORM;
                end
                NORM: begin
                    mant_q   <= norm_bits[2*W_Sgf-2:W_Sgf-1];
                    guard_q  <= norm_bits[W_Sgf-2];
                    sticky_q <= sticky_n;
                    zero_q   <= ~|prod_q;
                    exp_q    <= exp_q + {{W_Exp{1'b0}}, hi};
                    state    <= ROUND;
                end
                ROUND: begin
                    sum_q <= sum_n;
                    state <= RENORM;
                end
                RENORM: begin
                    // Zero beats overflow: a zero product never saturates.
                    if (zero_q) begin
                        bus.Sgf_Out   <= '0;
                        bus.Exp_Out   <= '0;
                        bus.Ovf_Flag  <= 1'b0;
                        bus.Zero_Flag <= 1'b1;
                    end else if (ovf_r) begin
                        bus.Sgf_Out   <= '0;
                        bus.Exp_Out   <= '1;
                        bus.Ovf_Flag  <= 1'b1;
                        bus.Zero_Flag <= 1'b0;
                    end else begin
                        bus.Sgf_Out   <= frac_r;
                        bus.Exp_Out   <= exp_r[W_Exp-1:0];
                        bus.Ovf_Flag  <= 1'b0;
                        bus.Zero_Flag <= 1'b0;
                    end
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sgf_norm_round.sv
// Randomized bench for sgf_norm_round: a value-level rounding model predicts each result,
// and one compare process checks the held outputs on every cycle.
module tb_sgf_norm_round;
    localparam int W_SGF = 53;
    localparam int W_EXP = 11;
    localparam int PW    = 2*W_SGF + 2;
    localparam int EW    = W_EXP + 1;

    typedef struct {
        logic [W_SGF-2:0] frac;
        logic [W_EXP-1:0] expo;
        logic             ovf;
        logic             zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sgf_norm_round_if #(.W_Sgf(W_SGF), .W_Exp(W_EXP)) bus ();
    sgf_norm_round #(.W_Sgf(W_SGF), .W_Exp(W_EXP)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int   checks = 0;
    int   errors = 0;
    res_t pending[$];
    res_t hold;
    bit   armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Value-level reference: keep the integer part of the normalized product,
    // compare the discarded remainder against one half, break ties to even.
    function automatic res_t model(input logic [PW-1:0] p, input logic [EW-1:0] e);
        res_t r;
        logic [PW-1:0] one, m, rem, half;
        int sh, ee;
        one = 1;
        r = '{frac: '0, expo: '0, ovf: 1'b0, zero: 1'b0};
        if (p == 0) begin
            r.zero = 1'b1;
            return r;
        end
        sh   = p[2*W_SGF-1] ? 1 : 0;
        m    = p >> (W_SGF - 1 + sh);
        rem  = p & ((one << (W_SGF - 1 + sh)) - one);
        half = one << (W_SGF - 2 + sh);
        if (rem > half || (rem == half && m[0])) m = m + one;
        ee = int'(e) + sh;
        if (m == (one << W_SGF)) begin
            m  = one << (W_SGF - 1);
            ee = ee + 1;
        end
        if (ee >= (1 << W_EXP) - 1) begin
            r.ovf  = 1'b1;
            r.expo = '1;
        end else begin
            r.frac = m[W_SGF-2:0];
            r.expo = ee[W_EXP-1:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            pending.delete();
            hold  = '{frac: '0, expo: '0, ovf: 1'b0, zero: 1'b0};
            armed = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (bus.done === 1'b1) begin
                if (pending.size() == 0) check("spurious_done", 1, 0);
                else hold = pending.pop_front();
            end
            check("sgf_out",   64'(bus.Sgf_Out),   64'(hold.frac));
            check("exp_out",   64'(bus.Exp_Out),   64'(hold.expo));
            check("ovf_flag",  64'(bus.Ovf_Flag),  64'(hold.ovf));
            check("zero_flag", 64'(bus.Zero_Flag), 64'(hold.zero));
        end
    end

    // One operation; with poke set, start is held high while the DUT is busy.
    task automatic run_op(input logic [PW-1:0] p, input logic [EW-1:0] e, input bit poke);
        int n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.P_Sgf  = p;
        bus.Exp_In = e;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pending.push_back(model(p, e));
        check("busy_after_start", 64'(bus.busy), 1);
        n = 0;
        while (bus.done !== 1'b1 && n < 10) begin
            if (poke && n == 1) begin
                bus.start  = 1'b1;
                bus.P_Sgf  = '0;
                bus.Exp_In = '0;
            end
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 3);
        check("busy_with_done", 64'(bus.busy), 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("done_pulse_len", 64'(bus.done), 0);
        check("busy_cleared", 64'(bus.busy), 0);
        if (poke) begin
            @(posedge clk); #1;
            check("no_reaccept", 64'(bus.busy), 0);
        end
    endtask

    function automatic logic [W_SGF-1:0] rand_sig();
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[W_SGF-1] = 1'b1;
        return r[W_SGF-1:0];
    endfunction

    initial begin
        logic [PW-1:0] one, p, a, b;
        logic [EW-1:0] e;
        res_t r;
        int sh;
        one = 1;

        rst = 1'b1;
        bus.start  = 1'b0;
        bus.P_Sgf  = '0;
        bus.Exp_In = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-derived results pin the model before it is trusted on random data.
        p = one << 104;
        r = model(p, 12'd1023);
        check("m_1x1_frac", 64'(r.frac), 0);
        check("m_1x1_exp",  64'(r.expo), 1023);
        run_op(p, 12'd1023, 1'b0);

        p = (one << 105) | (one << 102);
        r = model(p, 12'd1023);
        check("m_15x15_frac", 64'(r.frac), 64'(1) << 49);
        check("m_15x15_exp",  64'(r.expo), 1024);
        run_op(p, 12'd1023, 1'b0);

        p = (one << 104) | (one << 52) | (one << 51);
        r = model(p, 12'd500);
        check("m_tie_odd", 64'(r.frac), 2);
        run_op(p, 12'd500, 1'b0);

        p = (one << 104) | (one << 51);
        r = model(p, 12'd500);
        check("m_tie_even", 64'(r.frac), 0);
        run_op(p, 12'd500, 1'b0);

        p = ((one << 54) - one) << 51;
        r = model(p, 12'd1000);
        check("m_carry_frac", 64'(r.frac), 0);
        check("m_carry_exp",  64'(r.expo), 1001);
        run_op(p, 12'd1000, 1'b0);

        p = one << 105;
        r = model(p, 12'd2046);
        check("m_ovf_flag", 64'(r.ovf), 1);
        check("m_ovf_exp",  64'(r.expo), 2047);
        run_op(p, 12'd2046, 1'b0);

        r = model('0, 12'd2046);
        check("m_zero_flag", 64'(r.zero), 1);
        check("m_zero_ovf",  64'(r.ovf), 0);
        run_op('0, 12'd2046, 1'b0);

        run_op(one << 104, 12'd2048, 1'b0);
        run_op((one << 104) | 1, 12'd0, 1'b0);
        run_op((one << 105) | (one << 60), 12'd1500, 1'b1);

        for (int i = 0; i < 150; i++) begin
            a = PW'(rand_sig());
            b = PW'(rand_sig());
            p = a * b;
            e = EW'($urandom_range(0, 4000));
            case ($urandom_range(0, 9))
                0: p = '0;
                1, 2: begin
                    sh = p[2*W_SGF-1] ? 1 : 0;
                    p = ((p >> (W_SGF - 1 + sh)) << (W_SGF - 1 + sh)) | (one << (W_SGF - 2 + sh));
                end
                3: e = EW'($urandom_range(2040, 2050));
                default: ;
            endcase
            run_op(p, e, ($urandom_range(0, 7) == 0));
        end

        // Reset while the operation sits in ROUND: it must vanish without a done.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.P_Sgf  = one << 104;
        bus.Exp_In = 12'd1023;
        @(posedge clk); #1;
        bus.start = 1'b0;
        pending.push_back(model(one << 104, 12'd1023));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_busy", 64'(bus.busy), 0);
        check("rst_mid_done", 64'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 64'(bus.done), 0);
        end
        run_op((one << 105) | (one << 3), 12'd700, 1'b0);
        repeat (4) @(posedge clk);
        check("queue_drained", 64'(pending.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
